fir_coef_loader: RTL

Run-time coefficient writer for the FIR filter datapath. It accepts a stream of ORDER coefficients over a valid/ready handshake and writes them into a shadow bank. It then commits the shadow bank to the active bank atomically on a sample boundary. The active bank drives the filter's multiplier inputs as a flattened bus, so coefficients never change in the middle of a sample.

---
 rtl/fir_coef_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fir_coef_loader.sv
// Run-time FIR coefficient loader: streams ORDER words into a shadow bank and
// commits it to the active bank on sample_tick. Optional checksum word: FIR_COEF_CHECKSUM_EN.
module fir_coef_loader #(
  parameter int WIDTH = 16,
  parameter int ORDER = 53,
  parameter int IDX_W = $clog2(ORDER)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   coef_valid,
  input  logic [WIDTH-1:0]       coef_data,
  output logic                   coef_ready,
  input  logic                   sample_tick,
  output logic [ORDER*WIDTH-1:0] coeffs_flat,
  output logic                   busy,
  output logic                   load_done,
  output logic                   load_err,
  output logic [IDX_W-1:0]       wr_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             load_done_q, load_done_d;
  logic             load_err_q, load_err_d;
  logic             shadow_we;
  logic             commit;

`ifdef FIR_COEF_CHECKSUM_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cksum_phase_q, cksum_phase_d;
`endif

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    shadow_we   = 1'b0;
    commit      = 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
    acc_d         = acc_q;
    cksum_phase_d = cksum_phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = LOAD;
          wr_idx_d = '0;
`ifdef FIR_COEF_CHECKSUM_EN
          acc_d         = '0;
          cksum_phase_d = 1'b0;
`endif
        end
      end
      LOAD, WAIT_SWAP: begin
        if (load_start) begin
          // Restart wins over a coincident word or tick.
          state_d    = LOAD;
          wr_idx_d   = '0;
          load_err_d = 1'b1;
`ifdef FIR_COEF_CHECKSUM_EN
          acc_d         = '0;
          cksum_phase_d = 1'b0;
`endif
        end else if (state_q == WAIT_SWAP) begin
          if (sample_tick) begin
            commit      = 1'b1;
            state_d     = IDLE;
            load_done_d = 1'b1;
          end
`ifdef FIR_COEF_CHECKSUM_EN
        end else if (coef_valid && cksum_phase_q) begin
          cksum_phase_d = 1'b0;
          if (coef_data == acc_q) begin
            state_d = WAIT_SWAP;
          end else begin
            state_d    = IDLE;
            load_err_d = 1'b1;
          end
`endif
        end else if (coef_valid) begin
          shadow_we = 1'b1;
`ifdef FIR_COEF_CHECKSUM_EN
          acc_d = acc_q + coef_data;
`endif
          if (wr_idx_q == IDX_W'(ORDER - 1)) begin
`ifdef FIR_COEF_CHECKSUM_EN
            cksum_phase_d = 1'b1;
`else
            state_d = WAIT_SWAP;
`endif
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
      acc_q         <= '0;
      cksum_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef FIR_COEF_CHECKSUM_EN
      acc_q         <= acc_d;
      cksum_phase_q <= cksum_phase_d;
`endif
    end
  end

  // Per-tap shadow/active registers; every tap commits on the same edge.
  for (genvar gi = 0; gi < ORDER; gi++) begin : g_tap
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;

    always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (shadow_we && (wr_idx_q == IDX_W'(gi))) shadow_d = coef_data;
      if (commit) active_d = shadow_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end

    assign coeffs_flat[gi*WIDTH +: WIDTH] = active_q;
  end

  assign coef_ready = (state_q == LOAD);
  assign busy       = (state_q == LOAD) || (state_q == WAIT_SWAP);
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign wr_idx     = wr_idx_q;

endmodule
